// File: rtl/vending_machine_param.sv
// -----------------------------------------------------------------------------
// vending_machine_param
//
// Purpose:
//   Parametrised coin-operated vending controller. It sits between the
//   coin-acceptor front end and the dispenser / change-hopper drivers.
//   - Maps each 2-bit coin code to a parameterised denomination.
//   - Accumulates credit.
//   - Issues a one-cycle vend pulse once credit reaches PRICE.
//   - Pays any remainder back as a train of CHG_UNIT change-coin pulses.
//   - Keeps a saturating count of sales.
//
// Optional feature (compile-time macro):
//   VEND_CANCEL_EN
//     When defined, a 'cancel' input exists. Cancel in COLLECT refunds the
//     credit through the change train, with no vend and no sale counted.
//
// Parameter legality (not checked in hardware):
//   - PRICE > 0, PRICE <= MAX_CREDIT, and PRICE is a multiple of CHG_UNIT.
//   - Every COIN_VALn is a nonzero multiple of CHG_UNIT.
//   - 2**CREDIT_W > MAX_CREDIT + max(COIN_VALn).
//
// Ports:
//   clk         in   1         system clock, rising edge
//   rst         in   1         asynchronous reset, active low
//   coin_valid  in   1         a coin is presented this cycle
//   coin        in   2         coin code, qualified by coin_valid
//   cancel      in   1         refund request (VEND_CANCEL_EN only)
//   vend        out  1         registered one-cycle dispense pulse
//   chg         out  1         registered; each high cycle returns one CHG_UNIT
//   coin_rej    out  1         registered one-cycle pulse: return presented coin
//   busy        out  1         high while in VEND or CHANGE
//   credit      out  CREDIT_W  current credit
//   sale_cnt    out  CNT_W     saturating count of vends
// -----------------------------------------------------------------------------
module vending_machine_param #(
  parameter int PRICE      = 15,
  parameter int COIN_VAL0  = 5,
  parameter int COIN_VAL1  = 10,
  parameter int COIN_VAL2  = 20,
  parameter int COIN_VAL3  = 25,
  parameter int CHG_UNIT   = 5,
  parameter int MAX_CREDIT = 60,
  parameter int CREDIT_W   = 7,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  output logic                vend,
  output logic                chg,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [CNT_W-1:0]    sale_cnt
);

  // One extra bit on the running sum means a coin that would push the
  // credit past MAX_CREDIT is detected instead of wrapping around.
  localparam int SUM_W = CREDIT_W + 1;

  localparam logic [SUM_W-1:0]    PRICE_S = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0]    MAX_S   = SUM_W'(MAX_CREDIT);
  localparam logic [SUM_W-1:0]    VAL0_S  = SUM_W'(COIN_VAL0);
  localparam logic [SUM_W-1:0]    VAL1_S  = SUM_W'(COIN_VAL1);
  localparam logic [SUM_W-1:0]    VAL2_S  = SUM_W'(COIN_VAL2);
  localparam logic [SUM_W-1:0]    VAL3_S  = SUM_W'(COIN_VAL3);
  localparam logic [CREDIT_W-1:0] CHG_U   = CREDIT_W'(CHG_UNIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  state_t state, state_d;

  logic [CREDIT_W-1:0] credit_d;
  logic [CNT_W-1:0]    sale_cnt_d;
  logic                vend_d;
  logic                chg_d;
  logic                coin_rej_d;
  logic                busy_d;
  logic [SUM_W-1:0]    sum;
  logic                cancel_req;

  // Denomination lookup for a coin code, in the widened sum domain.
  function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] code);
    logic [SUM_W-1:0] v;
    case (code)
      2'b00:   v = VAL0_S;
      2'b01:   v = VAL1_S;
      2'b10:   v = VAL2_S;
      default: v = VAL3_S;
    endcase
    return v;
  endfunction

  // Sales counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) r = v;
    else                    r = v + CNT_W'(1);
    return r;
  endfunction

`ifdef VEND_CANCEL_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
`endif

  assign sum = {1'b0, credit} + coin_value(coin);

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    credit_d   = credit;
    sale_cnt_d = sale_cnt;
    vend_d     = 1'b0;
    chg_d      = 1'b0;
    coin_rej_d = 1'b0;

    case (state)
      IDLE, COLLECT: begin
        if (cancel_req && (state == COLLECT)) begin
          // Refund: enter the change train as if after a vend, without
          // dispensing or counting a sale. A coin arriving in the same
          // cycle loses to the cancel and is handed back.
          chg_d      = 1'b1;
          credit_d   = credit - CHG_U;
          coin_rej_d = coin_valid;
          state_d    = CHANGE;
        end else if (coin_valid) begin
          if (sum > MAX_S) begin
            coin_rej_d = 1'b1;
          end else if (sum >= PRICE_S) begin
            credit_d   = CREDIT_W'(sum - PRICE_S);
            vend_d     = 1'b1;
            sale_cnt_d = sat_inc(sale_cnt);
            state_d    = VEND;
          end else begin
            credit_d = CREDIT_W'(sum);
            state_d  = COLLECT;
          end
        end
      end

      VEND: begin
        coin_rej_d = coin_valid;
        if (credit != '0) begin
          chg_d    = 1'b1;
          credit_d = credit - CHG_U;
          state_d  = CHANGE;
        end else begin
          state_d = IDLE;
        end
      end

      CHANGE: begin
        coin_rej_d = coin_valid;
        // chg drops on the edge at which credit has reached zero.
        if (credit != '0) begin
          chg_d    = 1'b1;
          credit_d = credit - CHG_U;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  assign busy_d = (state_d == VEND) || (state_d == CHANGE);

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      credit   <= '0;
      sale_cnt <= '0;
      vend     <= 1'b0;
      chg      <= 1'b0;
      coin_rej <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      credit   <= credit_d;
      sale_cnt <= sale_cnt_d;
      vend     <= vend_d;
      chg      <= chg_d;
      coin_rej <= coin_rej_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: doc/vending_machine_param.md
# vending_machine_param

Parametrised successor to the team's fixed-price chocolate vending FSM. Accepts coins from a 2-bit coin code with a valid strobe, maps each code to a parameterised denomination, accumulates credit, and issues a one-cycle vend pulse once credit reaches PRICE. Change is returned as a train of unit-coin pulses, and a saturating sales counter is maintained. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

## Interface
- PRICE, 15: item price in credit units; must be >0, ≤MAX_CREDIT and a multiple of CHG_UNIT.
- COIN_VAL0, 5: value of coin code 2'b00.
- COIN_VAL1, 10: value of coin code 2'b01.
- COIN_VAL2, 20: value of coin code 2'b10.
- COIN_VAL3, 25: value of coin code 2'b11. Every COIN_VALn must be a nonzero multiple of CHG_UNIT.
- CHG_UNIT, 5: value of one change coin.
- MAX_CREDIT, 60: highest credit ever held.
- CREDIT_W, 7: credit width; must satisfy 2^CREDIT_W > MAX_CREDIT + max COIN_VALn.
- CNT_W, 8: sales counter width.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- coin_valid  in  1  a coin is presented this cycle.
- coin  in  2  coin code, qualified by coin_valid.
- cancel  in  1  refund request; present only with VEND_CANCEL_EN.
- vend  out  1  registered one-cycle dispense pulse.
- chg  out  1  registered; each high cycle returns one CHG_UNIT coin.
- coin_rej  out  1  registered one-cycle pulse: the presented coin was rejected and must be returned.
- busy  out  1  high in VEND or CHANGE.
- credit  out  CREDIT_W  current credit.
- sale_cnt  out  CNT_W  saturating count of vends.

## Operation
- States: IDLE (credit=0), COLLECT (0<credit<PRICE), VEND, CHANGE.
- Reset (async, rst=0): state IDLE, credit=0, vend=0, chg=0, coin_rej=0, busy=0, sale_cnt=0.
- IDLE/COLLECT, coin_valid=1, sum = credit + COIN_VAL[coin]:
  - sum > MAX_CREDIT: coin_rej=1; credit unchanged.
  - sum ≥ PRICE: credit = sum − PRICE; vend=1; sale_cnt increments, saturating at all-ones; go to VEND.
  - otherwise: credit = sum; go to COLLECT.
- VEND, one cycle:
  - vend clears.
  - credit>0: chg=1, credit −= CHG_UNIT, go to CHANGE.
  - credit=0: go to IDLE.
- CHANGE:
  - credit>0: chg=1, credit −= CHG_UNIT.
  - credit=0: chg=0, go to IDLE.
- Coins arriving in VEND or CHANGE are rejected: coin_rej=1, credit unchanged.
- coin_rej is low in every cycle not following a rejection.
- Arithmetic is unsigned. The overflow check uses a CREDIT_W+1 bit sum, so there is no wrap-around.

## Timing
- Coin sampled at edge N:
  - credit is valid after edge N.
  - vend is high in cycle N→N+1.
  - coin_rej, if the coin is rejected, is high in cycle N→N+1.
- Change:
  - chg is high for exactly (remainder / CHG_UNIT) contiguous cycles, starting at edge N+1.
  - chg falls at the edge where credit is observed at 0.
- busy = (state==VEND) | (state==CHANGE), registered with the state.
- Back-to-back coins, one per cycle, are accepted in IDLE/COLLECT with no bubbles.
- Reset asserted mid-vend or mid-change:
  - all outputs clear immediately.
  - remaining change is forfeited; no partial chg train resumes.

## Configuration
- VEND_CANCEL_EN defined:
  - cancel port exists.
  - cancel=1 at an edge in COLLECT behaves like VEND with no vend and no sale_cnt increment: chg=1, credit −= CHG_UNIT, go to CHANGE.
  - cancel has priority over a coin in the same cycle; that coin gets coin_rej=1.
  - cancel in IDLE, VEND or CHANGE is ignored.
- VEND_CANCEL_EN undefined: no cancel port; credit is only released through a vend.

## Test plan
- Defaults, reset, then coin 01 (10) then 00 (5) on consecutive cycles -> credit 10 then 0; vend one cycle after the second coin; chg never high; sale_cnt=1.
- Coin 11 (25) from IDLE -> vend pulse; credit 10 after the vend edge; chg high for 2 cycles starting the next cycle; then IDLE with busy=0.
- Coin 00 while chg is active -> coin_rej one cycle; credit sequence unaffected; chg count still 2.
- PRICE=55, MAX_CREDIT=60: coins 20,20 then 25 -> third coin rejected (65>60), credit stays 40; then coin 10 -> vend; credit 50 −55? no: 40+10=50<55, credit 50; then coin 10 -> vend and credit 5, followed by 1 chg cycle.
- VEND_CANCEL_EN: coin 10, then cancel together with coin 00 -> coin_rej=1; chg high 2 cycles; credit 0; vend never high; sale_cnt unchanged.
- CNT_W=2: five vends -> sale_cnt reads 1,2,3,3,3. Separately, assert rst in the first chg cycle after a 25 coin -> all outputs 0 asynchronously; state IDLE after release.
